// File: rtl/sram_responder_pkg.sv
// Shared widths, lane-mask type and sweep states for the SRAM responder.
// Imported by sram_bank and sram_responder.
package sram_pkg;

   localparam int SRAM_DATA_W = 16;
   localparam int SRAM_ADDR_W = 20;

   // bit 1 = upper lane [15:8], bit 0 = lower lane [7:0]
   typedef logic [1:0] lane_mask_t;

   typedef enum logic [0:0] {
      SWEEP_IDLE  = 1'b0,
      SWEEP_CLEAR = 1'b1
   } sweep_state_e;

   function automatic lane_mask_t lanes_from_n(input logic ub_n, input logic lb_n);
      return {~ub_n, ~lb_n};
   endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Initiator-side SRAM bus bundle (controls, address, write data).
// master drives the bus, slave observes it.
interface sram_responder_if;
   import sram_pkg::*;

   logic                   ce_n;
   logic                   we_n;
   logic                   oe_n;
   logic                   ub_n;
   logic                   lb_n;
   logic [SRAM_ADDR_W-1:0] addr;
   logic [SRAM_DATA_W-1:0] dq_wr;

   modport master (
      output ce_n, we_n, oe_n, ub_n, lb_n, addr, dq_wr
   );

   modport slave (
      input ce_n, we_n, oe_n, ub_n, lb_n, addr, dq_wr
   );

endinterface

// File: rtl/sram_responder_bank.sv
// sram_bank: 2^ADDR_W x 16 storage with per-byte-lane writes and a
// registered read port. Contents are never reset.
module sram_bank
   import sram_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic                   clk,
   input  logic                   we_i,
   input  lane_mask_t             wmask_i,
   input  logic [ADDR_W-1:0]      waddr_i,
   input  logic [SRAM_DATA_W-1:0] wdata_i,
   input  logic                   re_i,
   input  logic [ADDR_W-1:0]      raddr_i,
   output logic [SRAM_DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [SRAM_DATA_W-1:0] mem_q [0:DEPTH-1];
   logic [SRAM_DATA_W-1:0] rdata_q;

   // lane-masked write; untouched lanes keep their old value
   always_ff @(posedge clk) begin
      if (we_i) begin
         if (wmask_i[1]) mem_q[waddr_i][15:8] <= wdata_i[15:8];
         if (wmask_i[0]) mem_q[waddr_i][7:0]  <= wdata_i[7:0];
      end
   end

   // registered read, only updated when a read is issued
   always_ff @(posedge clk) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// sram_responder: async SRAM slave model with byte lanes, 1/2-cycle read
// latency, out-of-range flag. SRAM_RESP_INIT_CLR_EN adds a zeroing sweep.
module sram_responder
   import sram_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int READ_LAT = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_SRAM_CE_N,
   input  logic                   i_SRAM_WE_N,
   input  logic                   i_SRAM_OE_N,
   input  logic                   i_SRAM_UB_N,
   input  logic                   i_SRAM_LB_N,
   input  logic [SRAM_ADDR_W-1:0] i_SRAM_ADDR,
   input  logic [SRAM_DATA_W-1:0] i_SRAM_DQ_WR,
   output logic [SRAM_DATA_W-1:0] o_SRAM_DQ_RD,
   output logic                   o_SRAM_DQ_OE,
   output logic                   o_rd_valid,
   output logic                   o_addr_oor,
   output logic                   o_busy
);

   logic              sweep;
   logic [ADDR_W-1:0] sweep_addr;

`ifdef SRAM_RESP_INIT_CLR_EN
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   // sweep walks every address once, then hands over to normal accesses
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == '1) state_d = S_IDLE;
      end
   end

   // reset always restarts the sweep from address 0
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sweep      = (state_q == S_CLEAR);
   assign sweep_addr = cnt_q;
`else
   assign sweep      = 1'b0;
   assign sweep_addr = '0;
`endif

   assign o_busy = sweep;

   logic       active;
   logic       wr_req;
   logic       rd_issue;
   lane_mask_t lanes;

   assign active   = ~i_SRAM_CE_N & ~sweep;
   assign lanes    = lanes_from_n(i_SRAM_UB_N, i_SRAM_LB_N);
   assign wr_req   = active & ~i_SRAM_WE_N & (lanes != 2'b00);
   // WE_N low always wins over OE_N, so reads need WE_N high
   assign rd_issue = active & i_SRAM_WE_N & ~i_SRAM_OE_N;

   logic                   bank_we;
   lane_mask_t             bank_mask;
   logic [ADDR_W-1:0]      bank_waddr;
   logic [SRAM_DATA_W-1:0] bank_wdata;
   logic [SRAM_DATA_W-1:0] bank_rdata;

   assign bank_we    = sweep | wr_req;
   assign bank_mask  = sweep ? 2'b11 : lanes;
   assign bank_waddr = sweep ? sweep_addr : i_SRAM_ADDR[ADDR_W-1:0];
   assign bank_wdata = sweep ? '0 : i_SRAM_DQ_WR;

   sram_bank #(
      .ADDR_W (ADDR_W)
   ) u_bank (
      .clk     (i_clk),
      .we_i    (bank_we),
      .wmask_i (bank_mask),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata),
      .re_i    (rd_issue),
      .raddr_i (i_SRAM_ADDR[ADDR_W-1:0]),
      .rdata_o (bank_rdata)
   );

   logic upper_nz;

   generate
      if (ADDR_W < SRAM_ADDR_W) begin : g_oor
         assign upper_nz = |i_SRAM_ADDR[SRAM_ADDR_W-1:ADDR_W];
      end else begin : g_no_oor
         assign upper_nz = 1'b0;
      end
   endgenerate

   logic oor_q, oor_d;
   logic v1_q, v1_d;

   assign oor_d = active & upper_nz;
   assign v1_d  = rd_issue;

   // first latency stage and the one-cycle out-of-range pulse
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         oor_q <= 1'b0;
         v1_q  <= 1'b0;
      end else begin
         oor_q <= oor_d;
         v1_q  <= v1_d;
      end
   end

   logic                   lat_valid;
   logic [SRAM_DATA_W-1:0] lat_data;

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic                   v2_q, v2_d;
         logic [SRAM_DATA_W-1:0] d2_q, d2_d;

         assign v2_d = v1_q;
         assign d2_d = v1_q ? bank_rdata : '0;

         // second stage; reset discards anything in flight
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               v2_q <= 1'b0;
               d2_q <= '0;
            end else begin
               v2_q <= v2_d;
               d2_q <= d2_d;
            end
         end

         assign lat_valid = v2_q;
         assign lat_data  = d2_q;
      end else begin : g_lat1
         assign lat_valid = v1_q;
         assign lat_data  = bank_rdata;
      end
   endgenerate

   assign o_rd_valid   = lat_valid;
   assign o_SRAM_DQ_OE = lat_valid;
   assign o_SRAM_DQ_RD = lat_valid ? lat_data : '0;
   assign o_addr_oor   = oor_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: READ_LAT 1 and 2 instances (ADDR_W=10)
// and an ADDR_W=4 instance for the init sweep, all on one shared bus.
module tb_sram_responder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sram_responder_if bus ();

   logic [15:0] a_rd, b_rd, c_rd;
   logic        a_oe, a_v, a_oor, a_busy;
   logic        b_oe, b_v, b_oor, b_busy;
   logic        c_oe, c_v, c_oor, c_busy;

   sram_responder #(.ADDR_W(10), .READ_LAT(1)) dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_SRAM_CE_N(bus.ce_n), .i_SRAM_WE_N(bus.we_n),
      .i_SRAM_OE_N(bus.oe_n), .i_SRAM_UB_N(bus.ub_n),
      .i_SRAM_LB_N(bus.lb_n), .i_SRAM_ADDR(bus.addr),
      .i_SRAM_DQ_WR(bus.dq_wr), .o_SRAM_DQ_RD(a_rd),
      .o_SRAM_DQ_OE(a_oe), .o_rd_valid(a_v),
      .o_addr_oor(a_oor), .o_busy(a_busy)
   );

   sram_responder #(.ADDR_W(10), .READ_LAT(2)) dut_b (
      .i_clk(clk), .i_rst(rst),
      .i_SRAM_CE_N(bus.ce_n), .i_SRAM_WE_N(bus.we_n),
      .i_SRAM_OE_N(bus.oe_n), .i_SRAM_UB_N(bus.ub_n),
      .i_SRAM_LB_N(bus.lb_n), .i_SRAM_ADDR(bus.addr),
      .i_SRAM_DQ_WR(bus.dq_wr), .o_SRAM_DQ_RD(b_rd),
      .o_SRAM_DQ_OE(b_oe), .o_rd_valid(b_v),
      .o_addr_oor(b_oor), .o_busy(b_busy)
   );

   sram_responder #(.ADDR_W(4), .READ_LAT(1)) dut_c (
      .i_clk(clk), .i_rst(rst),
      .i_SRAM_CE_N(bus.ce_n), .i_SRAM_WE_N(bus.we_n),
      .i_SRAM_OE_N(bus.oe_n), .i_SRAM_UB_N(bus.ub_n),
      .i_SRAM_LB_N(bus.lb_n), .i_SRAM_ADDR(bus.addr),
      .i_SRAM_DQ_WR(bus.dq_wr), .o_SRAM_DQ_RD(c_rd),
      .o_SRAM_DQ_OE(c_oe), .o_rd_valid(c_v),
      .o_addr_oor(c_oor), .o_busy(c_busy)
   );

   // ctl = {ce_n, we_n, oe_n, ub_n, lb_n}
   typedef struct {
      logic [4:0]  ctl;
      logic [19:0] addr;
      logic [15:0] wd;
      logic        ev;
      logic [15:0] ed;
      logic        eoor;
   } vec_t;

   localparam logic [4:0] WR  = 5'b00100;
   localparam logic [4:0] RD  = 5'b01000;
   localparam logic [4:0] IDL = 5'b11100;

   int applied = 0;
   int miscompares = 0;
   int cyc = 0;

   vec_t vt [24];

   function automatic vec_t mk(input logic [4:0] c, input logic [19:0] a,
                               input logic [15:0] d, input logic ev,
                               input logic [15:0] ed, input logic eoor);
      vec_t v;
      v.ctl = c; v.addr = a; v.wd = d;
      v.ev = ev; v.ed = ed; v.eoor = eoor;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [4:0] c, input logic [19:0] a,
                        input logic [15:0] d);
      {bus.ce_n, bus.we_n, bus.oe_n, bus.ub_n, bus.lb_n} = c;
      bus.addr  = a;
      bus.dq_wr = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       pv;
      logic [15:0] pd;
      int         n;

      vt[0]  = mk(WR,      20'h00004, 16'hA5C3, 0, 16'h0000, 0);
      vt[1]  = mk(RD,      20'h00004, 16'h0000, 1, 16'hA5C3, 0);
      vt[2]  = mk(IDL,     20'h00000, 16'h0000, 0, 16'h0000, 0);
      vt[3]  = mk(WR,      20'h00010, 16'h1234, 0, 16'h0000, 0);
      vt[4]  = mk(5'b00110,20'h00010, 16'hFFEE, 0, 16'h0000, 0);
      vt[5]  = mk(RD,      20'h00010, 16'h0000, 1, 16'h12EE, 0);
      vt[6]  = mk(WR,      20'h00005, 16'h5678, 0, 16'h0000, 0);
      vt[7]  = mk(WR,      20'h00006, 16'h9ABC, 0, 16'h0000, 0);
      vt[8]  = mk(5'b00101,20'h00006, 16'hBBCC, 0, 16'h0000, 0);
      vt[9]  = mk(RD,      20'h00004, 16'h0000, 1, 16'hA5C3, 0);
      vt[10] = mk(RD,      20'h00005, 16'h0000, 1, 16'h5678, 0);
      vt[11] = mk(RD,      20'h00006, 16'h0000, 1, 16'hBBBC, 0);
      vt[12] = mk(5'b00000,20'h00401, 16'h0BEE, 0, 16'h0000, 1);
      vt[13] = mk(RD,      20'h00001, 16'h0000, 1, 16'h0BEE, 0);
      vt[14] = mk(5'b11000,20'h00004, 16'h0000, 0, 16'h0000, 0);
      vt[15] = mk(5'b01011,20'h00004, 16'h0000, 1, 16'hA5C3, 0);
      vt[16] = mk(5'b00111,20'h00004, 16'hFFFF, 0, 16'h0000, 0);
      vt[17] = mk(RD,      20'h00004, 16'h0000, 1, 16'hA5C3, 0);
      vt[18] = mk(RD,      20'hFFC04, 16'h0000, 1, 16'hA5C3, 1);
      vt[19] = mk(RD,      20'h00004, 16'h0000, 1, 16'hA5C3, 0);
      vt[20] = mk(5'b10100,20'h00004, 16'h0000, 0, 16'h0000, 0);
      vt[21] = mk(RD,      20'h00004, 16'h0000, 1, 16'hA5C3, 0);
      vt[22] = mk(IDL,     20'h00000, 16'h0000, 0, 16'h0000, 0);
      vt[23] = mk(IDL,     20'h00000, 16'h0000, 0, 16'h0000, 0);

      rst = 1'b1;
      drive(IDL, 20'h0, 16'h0);
      tick();
      tick();
      chk("rst_a_valid", {31'b0, a_v}, 0);
      chk("rst_a_data", {16'b0, a_rd}, 0);
      chk("rst_a_oe", {31'b0, a_oe}, 0);
      chk("rst_a_oor", {31'b0, a_oor}, 0);
      chk("rst_b_valid", {31'b0, b_v}, 0);
      chk("rst_b_data", {16'b0, b_rd}, 0);
      rst = 1'b0;
      cyc = 0;

`ifdef SRAM_RESP_INIT_CLR_EN
      #1;
      chk("busy_c_start", {31'b0, c_busy}, 1);
      chk("busy_a_start", {31'b0, a_busy}, 1);
      n = 0;
      while (c_busy && n < 64) begin
         if (n == 10) drive(WR, 20'h00002, 16'hFFFF);
         else drive(IDL, 20'h0, 16'h0);
         tick();
         n++;
      end
      chk("sweep_len_c", n, 16);
      for (int a = 0; a < 16; a++) begin
         drive(RD, 20'(a), 16'h0);
         tick();
         chk("sweep_rd_c_valid", {31'b0, c_v}, 1);
         chk("sweep_rd_c_data", {16'b0, c_rd}, 0);
         chk("sweep_rd_a_ignored", {31'b0, a_v}, 0);
      end
      drive(IDL, 20'h0, 16'h0);
      while (a_busy && cyc < 3000) tick();
      chk("sweep_len_a", cyc, 1024);
      chk("busy_b_end", {31'b0, b_busy}, 0);
`else
      chk("busy_a_off", {31'b0, a_busy}, 0);
      chk("busy_b_off", {31'b0, b_busy}, 0);
      chk("busy_c_off", {31'b0, c_busy}, 0);
`endif

      pv = 1'b0;
      pd = 16'h0000;
      for (int i = 0; i < 24; i++) begin
         drive(vt[i].ctl, vt[i].addr, vt[i].wd);
         tick();
         chk($sformatf("v%0d_a_valid", i), {31'b0, a_v}, {31'b0, vt[i].ev});
         chk($sformatf("v%0d_a_oe", i), {31'b0, a_oe}, {31'b0, vt[i].ev});
         chk($sformatf("v%0d_a_data", i), {16'b0, a_rd}, {16'b0, vt[i].ed});
         chk($sformatf("v%0d_a_oor", i), {31'b0, a_oor}, {31'b0, vt[i].eoor});
         chk($sformatf("v%0d_b_valid", i), {31'b0, b_v}, {31'b0, pv});
         chk($sformatf("v%0d_b_oe", i), {31'b0, b_oe}, {31'b0, pv});
         chk($sformatf("v%0d_b_data", i), {16'b0, b_rd}, {16'b0, pd});
         chk($sformatf("v%0d_b_oor", i), {31'b0, b_oor}, {31'b0, vt[i].eoor});
         chk($sformatf("v%0d_a_busy", i), {31'b0, a_busy}, 0);
         pv = vt[i].ev;
         pd = vt[i].ed;
      end

      drive(RD, 20'h00004, 16'h0);
      tick();
      drive(RD, 20'hFFC04, 16'h0);
      tick();
      drive(IDL, 20'h0, 16'h0);
      chk("pre_rst_b_valid", {31'b0, b_v}, 1);
      chk("pre_rst_a_oor", {31'b0, a_oor}, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_a_valid", {31'b0, a_v}, 0);
      chk("mid_rst_b_valid", {31'b0, b_v}, 0);
      chk("mid_rst_b_data", {16'b0, b_rd}, 0);
      chk("mid_rst_b_oe", {31'b0, b_oe}, 0);
      chk("mid_rst_a_oor", {31'b0, a_oor}, 0);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("post_rst_a_valid", {31'b0, a_v}, 0);
         chk("post_rst_b_valid", {31'b0, b_v}, 0);
         chk("post_rst_b_data", {16'b0, b_rd}, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
